pc_seq_ctrl: RTL and testbench

Next-PC sequencer and stall controller for the fetch stage. It drives the program counter's proposed-address and stall inputs, and selects among four sources: sequential PC+2, branch target, jump target and exception vector. It also merges hazard and instruction-memory stalls, holds redirects that arrive during stalls, and issues IF/ID flush pulses. It sits between the execute-stage branch/jump resolution logic, the hazard unit, the instruction memory and the PC register.

---
 rtl/pc_seq_ctrl_if.sv | 30 +++
 rtl/pc_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_ctrl_if.sv
// Next-PC sequencer bundle: PC/redirect/stall inputs and the proposed-address outputs.
// The sequencer connects through the slave modport; the driving side uses master.
interface pc_seq_ctrl_if;
    logic [15:0] pc;
    logic        hazard_stall;
    logic        imem_ready;
    logic        br_taken;
    logic [15:0] br_target;
    logic        jmp_valid;
    logic [15:0] jmp_target;
    logic        exc_valid;
    logic        halt_req;
    logic [15:0] next_addr;
    logic        pc_stall;
    logic        flush;
    logic        halted;
    logic        misalign_err;

    modport master (
        output pc, hazard_stall, imem_ready, br_taken, br_target,
               jmp_valid, jmp_target, exc_valid, halt_req,
        input  next_addr, pc_stall, flush, halted, misalign_err
    );

    modport slave (
        input  pc, hazard_stall, imem_ready, br_taken, br_target,
               jmp_valid, jmp_target, exc_valid, halt_req,
        output next_addr, pc_stall, flush, halted, misalign_err
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Fetch-stage next-PC sequencer and stall controller (boot, redirect, pend, halt).
// Define PC_SEQ_ALIGN_CHK_EN to trap odd jump/branch targets to EXC_VEC and flag misalign_err.
module pc_seq_ctrl #(
    parameter logic [15:0] RESET_VEC    = 16'h0000,
    parameter logic [15:0] EXC_VEC      = 16'h0002,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic          clk,
    input logic          rst,
    pc_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StBoot, StRun, StPend, StHalt} state_e;

    // The apply cycle itself is the first flush cycle, so the counter covers the remainder.
    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        halted_q;

    logic        stall;
    logic        halting;
    logic        redirect;
    logic        apply;
    logic [15:0] apply_addr;
    logic [15:0] raw_tgt;
    logic [15:0] run_tgt;
    logic [15:0] next_addr;
    logic        pc_stall;
    logic        flush;

    assign stall    = bus.hazard_stall | ~bus.imem_ready;
    assign halting  = bus.halt_req & ~bus.exc_valid;
    assign redirect = bus.exc_valid | bus.jmp_valid | bus.br_taken;

`ifdef PC_SEQ_ALIGN_CHK_EN
    logic mis_det;
    logic mis_q;
`endif

    // Redirect target selection: exception > jump > branch.
    always_comb begin
        raw_tgt = bus.jmp_valid ? bus.jmp_target : bus.br_target;
        run_tgt = raw_tgt;
`ifdef PC_SEQ_ALIGN_CHK_EN
        mis_det = 1'b0;
`endif
        if (bus.exc_valid) begin
            run_tgt = EXC_VEC;
        end
`ifdef PC_SEQ_ALIGN_CHK_EN
        else if (raw_tgt[0]) begin
            run_tgt = EXC_VEC;
            mis_det = (state_q == StRun) && !bus.halt_req && (bus.jmp_valid || bus.br_taken);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StBoot;
            pend_q   <= 16'h0000;
            cnt_q    <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            halted_q <= (state_d == StHalt);
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        apply      = 1'b0;
        apply_addr = run_tgt;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun: begin
                if (halting) begin
                    state_d = StHalt;
                end else if (redirect) begin
                    if (stall) begin
                        pend_d  = run_tgt;
                        state_d = StPend;
                    end else begin
                        apply = 1'b1;
                    end
                end
            end
            StPend: begin
                if (bus.exc_valid) begin
                    pend_d = EXC_VEC;
                end
                apply_addr = bus.exc_valid ? EXC_VEC : pend_q;
                if (halting) begin
                    state_d = StHalt;
                end else if (!stall) begin
                    apply   = 1'b1;
                    state_d = StRun;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_comb begin
        if (apply) begin
            cnt_d = FlushLoad;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end else begin
            cnt_d = 3'd0;
        end
    end

    always_comb begin
        next_addr = bus.pc;
        pc_stall  = 1'b1;
        flush     = 1'b0;
        unique case (state_q)
            StBoot: begin
                // While reset is held the stall stays up; BOOT releases it once rst deasserts.
                next_addr = RESET_VEC;
                pc_stall  = ~rst;
            end
            StRun, StPend: begin
                flush = apply | (cnt_q != 3'd0);
                if (apply) begin
                    next_addr = apply_addr;
                    pc_stall  = 1'b0;
                end else if (state_q == StRun && !stall && !halting) begin
                    next_addr = bus.pc + 16'd2;
                    pc_stall  = 1'b0;
                end
            end
            StHalt: begin
                flush = 1'b0;
            end
            default: begin
                pc_stall = 1'b1;
            end
        endcase
    end

    assign bus.next_addr = next_addr;
    assign bus.pc_stall  = pc_stall;
    assign bus.flush     = flush;
    assign bus.halted    = halted_q;

`ifdef PC_SEQ_ALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_det;
        end
    end

    assign bus.misalign_err = mis_q;
`else
    assign bus.misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: cycle table with a scoreboard queue, plus reset sequences.
// A second instance with FLUSH_CYCLES=3 shares the stimulus to check multi-cycle flush.
module tb_pc_seq_ctrl;
`ifdef PC_SEQ_ALIGN_CHK_EN
    localparam bit Align = 1'b1;
`else
    localparam bit Align = 1'b0;
`endif

    typedef struct {
        logic [15:0] pc;
        logic        hz;
        logic        rdy;
        logic        br;
        logic [15:0] brt;
        logic        jv;
        logic [15:0] jt;
        logic        ex;
        logic        ht;
        logic [15:0] na;
        logic        st;
        logic        fl1;
        logic        fl3;
        logic        hlt;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [15:0] na;
        logic        st;
        logic        fl1;
        logic        fl3;
        logic        hlt;
        logic        mis;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    vec_t tbl[27];

    pc_seq_ctrl_if ifc ();
    pc_seq_ctrl_if if3 ();

    assign if3.pc           = ifc.pc;
    assign if3.hazard_stall = ifc.hazard_stall;
    assign if3.imem_ready   = ifc.imem_ready;
    assign if3.br_taken     = ifc.br_taken;
    assign if3.br_target    = ifc.br_target;
    assign if3.jmp_valid    = ifc.jmp_valid;
    assign if3.jmp_target   = ifc.jmp_target;
    assign if3.exc_valid    = ifc.exc_valid;
    assign if3.halt_req     = ifc.halt_req;

    pc_seq_ctrl #(.FLUSH_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    pc_seq_ctrl #(.FLUSH_CYCLES(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] pc, input logic hz, input logic rdy,
                                input logic br, input logic [15:0] brt, input logic jv,
                                input logic [15:0] jt, input logic ex, input logic ht,
                                input logic [15:0] na, input logic st, input logic fl1,
                                input logic fl3, input logic hlt, input logic mis);
        vec_t v;
        v.pc = pc; v.hz = hz; v.rdy = rdy; v.br = br; v.brt = brt; v.jv = jv; v.jt = jt;
        v.ex = ex; v.ht = ht; v.na = na; v.st = st; v.fl1 = fl1; v.fl3 = fl3; v.hlt = hlt;
        v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".next_addr"}, ifc.next_addr, 16'h0000);
        chk({tag, ".pc_stall"}, {15'd0, ifc.pc_stall}, 16'd1);
        chk({tag, ".flush"}, {15'd0, ifc.flush}, 16'd0);
        chk({tag, ".flush3"}, {15'd0, if3.flush}, 16'd0);
        chk({tag, ".halted"}, {15'd0, ifc.halted}, 16'd0);
        chk({tag, ".misalign_err"}, {15'd0, ifc.misalign_err}, 16'd0);
    endtask

    // Drives one cycle just after the rising edge and compares at the falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        ifc.pc           = v.pc;
        ifc.hazard_stall = v.hz;
        ifc.imem_ready   = v.rdy;
        ifc.br_taken     = v.br;
        ifc.br_target    = v.brt;
        ifc.jmp_valid    = v.jv;
        ifc.jmp_target   = v.jt;
        ifc.exc_valid    = v.ex;
        ifc.halt_req     = v.ht;
        e.na = v.na; e.st = v.st; e.fl1 = v.fl1; e.fl3 = v.fl3; e.hlt = v.hlt; e.mis = v.mis;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, ".next_addr"}, ifc.next_addr, e.na);
        chk({tag, ".pc_stall"}, {15'd0, ifc.pc_stall}, {15'd0, e.st});
        chk({tag, ".flush"}, {15'd0, ifc.flush}, {15'd0, e.fl1});
        chk({tag, ".flush3"}, {15'd0, if3.flush}, {15'd0, e.fl3});
        chk({tag, ".halted"}, {15'd0, ifc.halted}, {15'd0, e.hlt});
        chk({tag, ".misalign_err"}, {15'd0, ifc.misalign_err}, {15'd0, e.mis});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        // pc, hz, rdy, br, brt, jv, jt, ex, ht | next_addr, stall, flush1, flush3, halted, mis
        tbl[0]  = mk(16'h0000, 0, 1, 1, 16'h0500, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        tbl[1]  = mk(16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 0, 0, 0, 0, 0);
        tbl[2]  = mk(16'h0002, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0004, 0, 0, 0, 0, 0);
        tbl[3]  = mk(16'hFFFE, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        tbl[4]  = mk(16'h0010, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 1, 0, 0, 0, 0);
        tbl[5]  = mk(16'h0010, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0010, 1, 0, 0, 0, 0);
        tbl[6]  = mk(16'h0010, 0, 1, 1, 16'h0040, 1, 16'h0080, 0, 0, 16'h0080, 0, 1, 1, 0, 0);
        tbl[7]  = mk(16'h0080, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0082, 0, 0, 1, 0, 0);
        tbl[8]  = mk(16'h0082, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0084, 0, 0, 1, 0, 0);
        tbl[9]  = mk(16'h0084, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0086, 0, 0, 0, 0, 0);
        tbl[10] = mk(16'h0086, 0, 0, 1, 16'h0100, 0, 16'h0000, 0, 0, 16'h0086, 1, 0, 0, 0, 0);
        tbl[11] = mk(16'h0086, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0086, 1, 0, 0, 0, 0);
        tbl[12] = mk(16'h0086, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0086, 1, 0, 0, 0, 0);
        tbl[13] = mk(16'h0086, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0100, 0, 1, 1, 0, 0);
        tbl[14] = mk(16'h0100, 0, 0, 0, 16'h0000, 1, 16'h0200, 0, 0, 16'h0100, 1, 0, 1, 0, 0);
        tbl[15] = mk(16'h0100, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0100, 1, 0, 1, 0, 0);
        tbl[16] = mk(16'h0100, 0, 0, 1, 16'h0300, 0, 16'h0000, 0, 0, 16'h0100, 1, 0, 0, 0, 0);
        tbl[17] = mk(16'h0100, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 0, 1, 1, 0, 0);
        tbl[18] = mk(16'h0002, 1, 1, 1, 16'h0400, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 1, 0, 0);
        tbl[19] = mk(16'h0002, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0002, 1, 0, 1, 0, 0);
        tbl[20] = mk(16'h0002, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 0, 1, 1, 0, 0);
        tbl[21] = mk(16'h0002, 0, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0002, 0, 1, 1, 0, 0);
        tbl[22] = mk(16'h0002, 0, 1, 0, 16'h0000, 1, 16'h0031, 0, 0,
                     Align ? 16'h0002 : 16'h0031, 0, 1, 1, 0, 0);
        tbl[23] = mk(16'h0040, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0042, 0, 0, 1, 0, Align);
        tbl[24] = mk(16'h0042, 0, 1, 1, 16'h0700, 0, 16'h0000, 0, 1, 16'h0042, 1, 0, 1, 0, 0);
        tbl[25] = mk(16'h0042, 0, 1, 1, 16'h0800, 0, 16'h0000, 1, 0, 16'h0042, 1, 0, 0, 1, 0);
        tbl[26] = mk(16'h0050, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0050, 1, 0, 0, 1, 0);

        rst              = 1'b0;
        ifc.pc           = 16'h0000;
        ifc.hazard_stall = 1'b0;
        ifc.imem_ready   = 1'b1;
        ifc.br_taken     = 1'b0;
        ifc.br_target    = 16'h0000;
        ifc.jmp_valid    = 1'b0;
        ifc.jmp_target   = 16'h0000;
        ifc.exc_valid    = 1'b0;
        ifc.halt_req     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("reset");

        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 27; i++) begin
            run_vec(tbl[i], $sformatf("row%0d", i));
        end

        // Asynchronous reset in the middle of HALT must restore reset outputs at once.
        #2;
        rst = 1'b0;
        #1;
        check_reset("halt_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_vec(mk(16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0),
                "reboot");
        run_vec(mk(16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 0, 0, 0, 0, 0),
                "rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
